// File: rtl/bopit_round_ctrl.sv
// Bop-It game-round sequencer.
// Draws a command serially from the RN_JESUS bit generator, prompts the player,
// times the response against a window that shrinks after every hit, keeps the
// score and flags game over.
// Optional build macro: BOPIT_ROUND_HISCORE_EN adds o_hiscore / o_new_hiscore.
module bopit_round_ctrl #(
  parameter int CMD_W        = 2,
  parameter int NUM_CMDS     = 3,
  parameter int TIMEOUT_W    = 28,
  parameter int TIMEOUT_INIT = 100000000,
  parameter int TIMEOUT_STEP = 5000000,
  parameter int TIMEOUT_MIN  = 25000000,
  parameter int SCORE_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_rand,
  output logic                o_rng_en,
  input  logic [NUM_CMDS-1:0] i_btn,
  output logic [CMD_W-1:0]    o_cmd,
  output logic                o_cmd_valid,
  output logic                o_hit,
  output logic [SCORE_W-1:0]  o_score,
  output logic                o_game_over,
  output logic                o_busy
`ifdef BOPIT_ROUND_HISCORE_EN
  ,
  output logic [SCORE_W-1:0]  o_hiscore,
  output logic                o_new_hiscore
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAW   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_PROMPT = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_HIT    = 3'd5;
  localparam logic [2:0] ST_OVER   = 3'd6;

  localparam int BIT_W = (CMD_W > 1) ? $clog2(CMD_W) : 1;
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(CMD_W - 1);
  localparam logic [CMD_W:0]       NCMD     = (CMD_W + 1)'(NUM_CMDS);
  localparam logic [TIMEOUT_W-1:0] T_INIT   = TIMEOUT_W'(TIMEOUT_INIT);
  localparam logic [TIMEOUT_W-1:0] T_STEP   = TIMEOUT_W'(TIMEOUT_STEP);
  localparam logic [TIMEOUT_W-1:0] T_MIN    = TIMEOUT_W'(TIMEOUT_MIN);
  // Smallest window that can still shrink by a full step without going below the floor
  localparam logic [TIMEOUT_W:0]   T_FLOOR  = (TIMEOUT_W + 1)'(TIMEOUT_MIN + TIMEOUT_STEP);

  logic [2:0]           state_reg, state_next;
  logic [CMD_W-1:0]     draw_reg, draw_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [1:0]           redraw_reg, redraw_next;
  logic [CMD_W-1:0]     cmd_reg, cmd_next;
  logic [TIMEOUT_W-1:0] timer_reg, timer_next;
  logic [TIMEOUT_W-1:0] timeout_reg, timeout_next;
  logic [SCORE_W-1:0]   score_reg, score_next;

  logic [NUM_CMDS-1:0]  cmd_onehot;
  logic [CMD_W:0]       draw_ext;
  logic [CMD_W:0]       draw_wrap;

  // One-hot image of the current command, compared against the button pulses
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CMDS; gi++) begin : g_onehot
      assign cmd_onehot[gi] = (cmd_reg == CMD_W'(gi));
    end
  endgenerate

  assign draw_ext  = {1'b0, draw_reg};
  assign draw_wrap = draw_ext - NCMD;

  // Next-state and datapath decisions for the round sequencer
  always_comb begin
    state_next   = state_reg;
    draw_next    = draw_reg;
    bit_cnt_next = bit_cnt_reg;
    redraw_next  = redraw_reg;
    cmd_next     = cmd_reg;
    timer_next   = timer_reg;
    timeout_next = timeout_reg;
    score_next   = score_reg;
    case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (i_start) begin
          score_next   = '0;
          timeout_next = T_INIT;
          state_next   = ST_DRAW;
        end
      end
      ST_DRAW: begin
        draw_next = {draw_reg[CMD_W-2:0], i_rand};
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_next = '0;
          state_next   = ST_CHECK;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      ST_CHECK: begin
        if (draw_ext < NCMD) begin
          cmd_next    = draw_reg;
          redraw_next = '0;
          state_next  = ST_PROMPT;
        end else if (redraw_reg < 2'd2) begin
          redraw_next = redraw_reg + 1'b1;
          state_next  = ST_DRAW;
        end else begin
          // Third rejection in a row: fold the value into range so a stuck RNG cannot stall the game
          cmd_next    = draw_wrap[CMD_W-1:0];
          redraw_next = '0;
          state_next  = ST_PROMPT;
        end
      end
      ST_PROMPT: begin
        timer_next = timeout_reg;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A button press is judged before the timer so a press on the last cycle still counts
        if (i_btn != '0) begin
          state_next = (i_btn == cmd_onehot) ? ST_HIT : ST_OVER;
        end else if (timer_reg == '0) begin
          state_next = ST_OVER;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      ST_HIT: begin
        if (score_reg != '1) begin
          score_next = score_reg + 1'b1;
        end
        if ({1'b0, timeout_reg} >= T_FLOOR) begin
          timeout_next = timeout_reg - T_STEP;
        end else begin
          timeout_next = T_MIN;
        end
        state_next = ST_DRAW;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      draw_reg    <= '0;
      bit_cnt_reg <= '0;
      redraw_reg  <= '0;
      cmd_reg     <= '0;
      timer_reg   <= '0;
      timeout_reg <= T_INIT;
      score_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      draw_reg    <= draw_next;
      bit_cnt_reg <= bit_cnt_next;
      redraw_reg  <= redraw_next;
      cmd_reg     <= cmd_next;
      timer_reg   <= timer_next;
      timeout_reg <= timeout_next;
      score_reg   <= score_next;
    end
  end

  assign o_rng_en    = (state_reg == ST_DRAW);
  assign o_cmd       = cmd_reg;
  assign o_cmd_valid = (state_reg == ST_PROMPT) || (state_reg == ST_WAIT);
  assign o_hit       = (state_reg == ST_HIT);
  assign o_score     = score_reg;
  assign o_game_over = (state_reg == ST_OVER);
  assign o_busy      = (state_reg != ST_IDLE) && (state_reg != ST_OVER);

`ifdef BOPIT_ROUND_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_reg;
  logic               new_hiscore_reg;

  // Capture a new best score as the game ends; score is stable across the WAIT->OVER edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hiscore_reg     <= '0;
      new_hiscore_reg <= 1'b0;
    end else begin
      new_hiscore_reg <= 1'b0;
      if ((state_reg != ST_OVER) && (state_next == ST_OVER) && (score_reg > hiscore_reg)) begin
        hiscore_reg     <= score_reg;
        new_hiscore_reg <= 1'b1;
      end
    end
  end

  assign o_hiscore     = hiscore_reg;
  assign o_new_hiscore = new_hiscore_reg;
`endif

endmodule
